// File: rtl/forwarding_scoreboard.sv
// Forwarding and hazard unit: shadows in-flight destination registers, picks the
// youngest producer per source operand and stalls decode when that result is not ready.
module forwarding_scoreboard #(
  parameter int NSRC       = 2,
  parameter int NFWD       = 3,
  parameter int LATE_STAGE = 1,
  parameter int REGW       = 5,
  parameter int DW         = 32,
  parameter int SELW       = $clog2(NFWD + 1),
  parameter logic [15:0] STALL_CNT_RST = 16'h0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic                   issue_regwr,
  input  logic [REGW-1:0]        issue_wsel,
  input  logic                   issue_late,
  input  logic [NSRC*REGW-1:0]   src_sel,
  input  logic [NSRC*DW-1:0]     rf_data,
  input  logic [NFWD*DW-1:0]     stage_data,
  input  logic                   mem_wait,
  output logic [NSRC*DW-1:0]     src_data,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   stall,
  output logic [NFWD-1:0]        stage_valid,
  output logic [15:0]            stall_count
);

  logic [NFWD-1:0]           r_vld;
  logic [NFWD-1:0]           r_late;
  logic [NFWD-1:0][REGW-1:0] r_wsel;
  logic [15:0]               r_stall_cnt;

  logic [NFWD-1:0] w_ready;
  logic            w_stall;

  // Late entries only become usable once they reach LATE_STAGE without a miss.
  always_comb begin
    for (int k = 0; k < NFWD; k++) begin
      w_ready[k] = r_vld[k] && (!r_late[k] || (k > LATE_STAGE) ||
                                ((k == LATE_STAGE) && !mem_wait));
    end
  end

  always_comb begin
    logic            w_hit;
    logic            w_win_rdy;
    int              w_win;
    logic [REGW-1:0] w_src;
    w_stall  = 1'b0;
    fwd_sel  = '0;
    src_data = rf_data;
    for (int i = 0; i < NSRC; i++) begin
      w_hit     = 1'b0;
      w_win_rdy = 1'b0;
      w_win     = 0;
      w_src     = src_sel[i*REGW +: REGW];
      // Scan oldest to youngest so the youngest match overwrites.
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (r_vld[k] && (r_wsel[k] == w_src) && (w_src != '0)) begin
          w_hit     = 1'b1;
          w_win     = k;
          w_win_rdy = w_ready[k];
        end
      end
      if (w_hit) begin
        fwd_sel[i*SELW +: SELW] = SELW'(w_win + 1);
        if (w_win_rdy) begin
          src_data[i*DW +: DW] = stage_data[w_win*DW +: DW];
        end else if (issue_valid) begin
          w_stall = 1'b1;
        end
      end
    end
  end

  assign stall       = w_stall;
  assign stage_valid = r_vld;
  assign stall_count = r_stall_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld       <= '0;
      r_late      <= '0;
      r_wsel      <= '0;
      r_stall_cnt <= STALL_CNT_RST;
    end else if (advance) begin
      for (int k = NFWD - 1; k > 0; k--) begin
        r_vld[k]  <= r_vld[k-1];
        r_late[k] <= r_late[k-1];
        r_wsel[k] <= r_wsel[k-1];
      end
      r_vld[0]  <= issue_valid && issue_regwr && (issue_wsel != '0) && !w_stall && !flush;
      r_late[0] <= issue_late;
      r_wsel[0] <= issue_wsel;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: stimulus pushes expected results into a
// queue, an independent monitor pops and compares them on the falling clock edge.
module tb_forwarding_scoreboard;

  localparam logic [31:0] RF0 = 32'hA0A0_0000;
  localparam logic [31:0] RF1 = 32'hB0B0_0001;
  localparam logic [31:0] S0  = 32'h5000_0000;
  localparam logic [31:0] S1  = 32'h5100_0001;
  localparam logic [31:0] S2  = 32'h5200_0002;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        advance = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_regwr = 1'b0;
  logic [4:0]  issue_wsel = '0;
  logic        issue_late = 1'b0;
  logic [9:0]  src_sel = '0;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic        mem_wait = 1'b0;
  logic [63:0] src_data;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [2:0]  stage_valid;
  logic [15:0] stall_count;

  logic [63:0] sat_src_data;
  logic [3:0]  sat_fwd_sel;
  logic        sat_stall;
  logic [2:0]  sat_stage_valid;
  logic [15:0] sat_stall_count;

  assign rf_data    = {RF1, RF0};
  assign stage_data = {S2, S1, S0};

  forwarding_scoreboard dut (
    .CLK(CLK), .RST(RST), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_regwr(issue_regwr), .issue_wsel(issue_wsel),
    .issue_late(issue_late), .src_sel(src_sel), .rf_data(rf_data),
    .stage_data(stage_data), .mem_wait(mem_wait), .src_data(src_data),
    .fwd_sel(fwd_sel), .stall(stall), .stage_valid(stage_valid),
    .stall_count(stall_count)
  );

  // Second copy whose counter starts near the top, to reach saturation quickly.
  forwarding_scoreboard #(.STALL_CNT_RST(16'hFFFE)) dut_sat (
    .CLK(CLK), .RST(RST), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_regwr(issue_regwr), .issue_wsel(issue_wsel),
    .issue_late(issue_late), .src_sel(src_sel), .rf_data(rf_data),
    .stage_data(stage_data), .mem_wait(mem_wait), .src_data(sat_src_data),
    .fwd_sel(sat_fwd_sel), .stall(sat_stall), .stage_valid(sat_stage_valid),
    .stall_count(sat_stall_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [3:0]  sel;
    logic [63:0] data;
    logic        chk_d;
    logic        stl;
    logic [2:0]  sv;
    logic [15:0] cnt;
    logic [15:0] cnt_sat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] exp_data(input logic [1:0] sel, input int src);
    case (sel)
      2'd1:    return S0;
      2'd2:    return S1;
      2'd3:    return S2;
      default: return (src == 1) ? RF1 : RF0;
    endcase
  endfunction

  task automatic chk(input string nm, input string fld, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, want);
    end
  endtask

  task automatic step(input string nm, input logic v, input logic rw,
                      input logic [4:0] ws, input logic lt, input logic fl,
                      input logic adv, input logic mw, input logic [4:0] a0,
                      input logic [4:0] a1, input logic [1:0] e0, input logic [1:0] e1,
                      input logic estl, input logic chkd, input logic [2:0] esv,
                      input logic [15:0] ecnt, input logic [15:0] esat,
                      input logic rmid);
    exp_t e;
    issue_valid = v;
    issue_regwr = rw;
    issue_wsel  = ws;
    issue_late  = lt;
    flush       = fl;
    advance     = adv;
    mem_wait    = mw;
    src_sel     = {a1, a0};
    e.nm      = nm;
    e.sel     = {e1, e0};
    e.data    = {exp_data(e1, 1), exp_data(e0, 0)};
    e.chk_d   = chkd;
    e.stl     = estl;
    e.sv      = esv;
    e.cnt     = ecnt;
    e.cnt_sat = esat;
    exp_q.push_back(e);
    if (rmid) begin
      #1 RST = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (rmid) RST = 1'b0;
  endtask

  initial begin : monitor
    exp_t r;
    forever begin
      @(negedge CLK);
      while (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk(r.nm, "fwd_sel", 64'(fwd_sel), 64'(r.sel));
        chk(r.nm, "stall", 64'(stall), 64'(r.stl));
        chk(r.nm, "stage_valid", 64'(stage_valid), 64'(r.sv));
        chk(r.nm, "stall_count", 64'(stall_count), 64'(r.cnt));
        chk(r.nm, "sat_count", 64'(sat_stall_count), 64'(r.cnt_sat));
        if (r.chk_d) chk(r.nm, "src_data", src_data, r.data);
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    //    name            v  rw ws  lt fl adv mw a0  a1  e0 e1 stl cd sv      cnt    sat       rmid
    step("reset",         0, 0, 0,  0, 0, 1, 0,  0,  0, 0, 0, 0, 1, 3'b000, 16'd0, 16'hFFFE, 0);
    step("addu3",         1, 1, 3,  0, 0, 1, 0,  0,  0, 0, 0, 0, 1, 3'b000, 16'd0, 16'hFFFE, 0);
    step("alu_fwd_s0",    1, 0, 0,  0, 0, 1, 0,  3,  0, 1, 0, 0, 1, 3'b001, 16'd0, 16'hFFFE, 0);
    step("alu_fwd_s1",    1, 0, 0,  0, 0, 1, 0,  3,  0, 2, 0, 0, 1, 3'b010, 16'd0, 16'hFFFE, 0);
    step("lw5",           1, 1, 5,  1, 0, 1, 0,  0,  3, 0, 3, 0, 1, 3'b100, 16'd0, 16'hFFFE, 0);
    step("load_use",      1, 1, 6,  0, 0, 1, 0,  5,  0, 1, 0, 1, 0, 3'b001, 16'd0, 16'hFFFE, 0);
    step("load_fwd",      1, 1, 6,  0, 0, 1, 0,  5,  0, 2, 0, 0, 1, 3'b010, 16'd1, 16'hFFFF, 0);
    step("iss7",          1, 1, 7,  0, 0, 1, 0,  0,  0, 0, 0, 0, 1, 3'b101, 16'd1, 16'hFFFF, 0);
    step("rd7_s0",        1, 0, 0,  0, 0, 1, 0,  7,  0, 1, 0, 0, 1, 3'b011, 16'd1, 16'hFFFF, 0);
    step("rd7_s1",        1, 1, 7,  0, 0, 1, 0,  7,  0, 2, 0, 0, 1, 3'b110, 16'd1, 16'hFFFF, 0);
    step("young_s0_s2",   1, 1, 7,  1, 0, 1, 0,  7,  0, 1, 0, 0, 1, 3'b101, 16'd1, 16'hFFFF, 0);
    step("young_late",    1, 0, 0,  0, 0, 1, 0,  7,  0, 1, 0, 1, 0, 3'b011, 16'd1, 16'hFFFF, 0);
    step("freeze1",       1, 0, 0,  0, 0, 0, 1,  7,  0, 2, 0, 1, 0, 3'b110, 16'd2, 16'hFFFF, 0);
    step("freeze2",       1, 0, 0,  0, 0, 0, 1,  7,  0, 2, 0, 1, 0, 3'b110, 16'd2, 16'hFFFF, 0);
    step("freeze3",       1, 0, 0,  0, 0, 0, 1,  7,  0, 2, 0, 1, 0, 3'b110, 16'd2, 16'hFFFF, 0);
    step("unfreeze",      1, 0, 0,  0, 0, 1, 0,  7,  0, 2, 0, 0, 1, 3'b110, 16'd2, 16'hFFFF, 0);
    step("zero_wr",       1, 1, 0,  0, 0, 1, 0,  0,  7, 0, 3, 0, 1, 3'b100, 16'd2, 16'hFFFF, 0);
    step("flush9",        1, 1, 9,  0, 1, 1, 0,  0,  0, 0, 0, 0, 1, 3'b000, 16'd2, 16'hFFFF, 0);
    step("read9",         1, 1, 10, 1, 0, 1, 0,  9,  0, 0, 0, 0, 1, 3'b000, 16'd2, 16'hFFFF, 0);
    step("flush_stall",   1, 1, 12, 0, 1, 1, 0,  10, 0, 1, 0, 1, 0, 3'b001, 16'd2, 16'hFFFF, 0);
    step("after_fs",      1, 0, 0,  0, 0, 1, 0,  0, 10, 0, 2, 0, 1, 3'b010, 16'd3, 16'hFFFF, 0);
    step("late_old",      1, 1, 11, 1, 0, 1, 0,  10, 0, 3, 0, 0, 1, 3'b100, 16'd3, 16'hFFFF, 0);
    step("hold_stall",    1, 1, 12, 0, 0, 0, 0,  11, 0, 1, 0, 1, 0, 3'b001, 16'd3, 16'hFFFF, 0);
    step("rst_mid",       1, 1, 12, 0, 0, 0, 0,  11, 0, 0, 0, 0, 1, 3'b000, 16'd0, 16'hFFFE, 1);
    step("post_rst",      1, 0, 0,  0, 0, 1, 0,  11, 0, 0, 0, 0, 1, 3'b000, 16'd0, 16'hFFFE, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("drain", "pending", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
